// File: rtl/instr_encoder.sv
// MIPS instruction encoder: packs symbolic commands into 32-bit words, buffers them
// in a small FIFO and streams them to instruction memory. Option: ENC_ILLEGAL_CHECK_EN.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              wrapped,
    output logic              err_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  OCC_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
        OP_SLT  = 4'd4,  OP_LW   = 4'd5,  OP_SW   = 4'd6,  OP_BEQ  = 4'd7,
        OP_BNE  = 4'd8,  OP_ADDI = 4'd9,  OP_ORI  = 4'd10, OP_ANDI = 4'd11,
        OP_SLTI = 4'd12, OP_J    = 4'd13
    } op_e;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   occ;
    logic [31:0]      enc;
    logic             fifo_full, fifo_empty;
    logic             accept, push, pop, load, complete;

    assign fifo_full  = (occ == OCC_FULL);
    assign fifo_empty = (occ == '0);
    assign in_ready   = !fifo_full;
    assign accept     = in_valid && in_ready;
    assign complete   = wr_valid && wr_ready;
    // The output register refills when idle or when its word leaves on this edge.
    assign load       = !wr_valid || wr_ready;
    assign pop        = load && !fifo_empty;

    always_comb begin
        enc = 32'h0000_0000;
        case (in_op)
            OP_ADD:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
            OP_SUB:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
            OP_AND:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
            OP_OR:   enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
            OP_SLT:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b101010};
            OP_LW:   enc = {6'b100011, in_rs, in_rt, in_imm};
            OP_SW:   enc = {6'b101011, in_rs, in_rt, in_imm};
            OP_BEQ:  enc = {6'b000100, in_rs, in_rt, in_imm};
            OP_BNE:  enc = {6'b000101, in_rs, in_rt, in_imm};
            OP_ADDI: enc = {6'b001000, in_rs, in_rt, in_imm};
            OP_ORI:  enc = {6'b001101, in_rs, in_rt, in_imm};
            OP_ANDI: enc = {6'b001100, in_rs, in_rt, in_imm};
            OP_SLTI: enc = {6'b001010, in_rs, in_rt, in_imm};
            OP_J:    enc = {6'b000010, in_target};
            default: enc = 32'h0000_0000;
        endcase
    end

`ifdef ENC_ILLEGAL_CHECK_EN
    logic legal;
    assign legal = (in_op <= 4'd13);
    assign push  = accept && legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_illegal <= 1'b0;
        else if (clear)
            err_illegal <= 1'b0;
        else if (accept && !legal)
            err_illegal <= 1'b1;
    end
`else
    assign push        = accept;
    assign err_illegal = 1'b0;
`endif

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= enc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_valid <= 1'b0;
            wr_data  <= '0;
            wr_addr  <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
        end else if (clear) begin
            wr_valid <= 1'b0;
            wr_data  <= '0;
            wr_addr  <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
        end else begin
            if (complete) begin
                wr_addr <= wr_addr + 1'b1;
                if (count != COUNT_MAX)
                    count <= count + 1'b1;
                if (&wr_addr)
                    wrapped <= 1'b1;
            end
            if (load) begin
                wr_valid <= !fifo_empty;
                if (!fifo_empty)
                    wr_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a spec-level encoding model fills an expectation
// queue at acceptance; a negedge monitor pops and compares every completed write.
module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_op = '0;
    logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0]       in_imm = '0;
    logic [25:0]       in_target = '0;
    logic              wr_valid;
    logic              wr_ready = 1'b1;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   count;
    logic              wrapped;
    logic              err_illegal;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .wrapped(wrapped), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t              sb[$];
    logic [ADDR_W-1:0] model_addr = '0;
    int                model_count = 0;
    logic              model_wrapped = 1'b0;
    int                n_pass = 0;
    int                n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Encoding straight from the opcode/funct tables; returns {legal, word}.
    function automatic logic [32:0] model_enc(input int op, input int rs, input int rt,
                                              input int rd, input int imm, input int tgt);
        int r_funct[5] = '{32, 34, 36, 37, 42};
        int i_opc[8]   = '{35, 43, 4, 5, 8, 13, 12, 10};
        int w;
        if (op < 5)
            w = (rs << 21) + (rt << 16) + (rd << 11) + r_funct[op];
        else if (op < 13)
            w = (i_opc[op-5] << 26) + (rs << 21) + (rt << 16) + (imm & 16'hFFFF);
        else if (op == 13)
            w = (2 << 26) + (tgt & 26'h3FF_FFFF);
        else
            return {1'b0, 32'h0};
        return {1'b1, 32'(w)};
    endfunction

    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int imm, input int tgt);
        logic [32:0] m;
        int          n;
        @(negedge clk);
        in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 16'(imm); in_target = 26'(tgt);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        m = model_enc(op, rs, rt, rd, imm, tgt);
`ifdef ENC_ILLEGAL_CHECK_EN
        if (m[32]) begin
`else
        begin
`endif
            sb.push_back('{addr: model_addr, data: m[31:0]});
            model_addr = model_addr + 1'b1;
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || wr_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 64'(sb.size() == 0 && !wr_valid), 64'd1);
    endtask

    task automatic do_clear();
        @(posedge clk);
        #2 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        sb.delete();
        model_addr = '0; model_count = 0; model_wrapped = 1'b0;
    endtask

    // Monitor: every write presented with wr_ready high completes on the next edge.
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data  = '0;
        logic [ADDR_W-1:0] prev_addr = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && wr_valid) begin
                    check("hold_data", 64'(wr_data), 64'(prev_data));
                    check("hold_addr", 64'(wr_addr), 64'(prev_addr));
                end
                if (wr_valid && wr_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_write", 64'(wr_data), 64'hDEAD_0000_0000);
                    end else begin
                        e = sb.pop_front();
                        check("wr_addr", 64'(wr_addr), 64'(e.addr));
                        check("wr_data", 64'(wr_data), 64'(e.data));
                        if (model_count < (1 << ADDR_W)) model_count++;
                        if (e.addr == '1) model_wrapped = 1'b1;
                    end
                end
                prev_stall = wr_valid && !wr_ready;
                prev_data  = wr_data;
                prev_addr  = wr_addr;
            end
        end
    end

    initial begin
        bit rand_done;
        #22 reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_wrapped", 64'(wrapped), 64'd0);
        check("rst_err", 64'(err_illegal), 64'd0);

        // First write appears one cycle after acceptance.
        send(9, 0, 8, 0, 5, 0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(wr_valid), 64'd1);
        check("lat_addr", 64'(wr_addr), 64'd0);
        check("lat_data", 64'(wr_data), 64'h2008_0005);
        send(0, 9, 10, 8, 0, 0);
        drain();
        check("add_count", 64'(count), 64'd2);

        do_clear();
        send(5, 29, 8, 0, 4, 0);
        send(7, 8, 9, 0, 16'hFFFF, 0);
        send(13, 0, 0, 0, 0, 26'h10);
        drain();
        check("b2b_count", 64'(count), 64'd3);

        // Back-pressure: 1 word in the output register plus DEPTH in the FIFO.
        @(posedge clk);
        #2 wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1, i, i + 1, i + 2, 0, 0);
        @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_wr_valid", 64'(wr_valid), 64'd1);
        repeat (3) @(negedge clk);
        check("stall_still_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2 wr_ready = 1'b1;
        send(4, 3, 4, 5, 0, 0);
        drain();
        check("stall_count", 64'(count), 64'(model_count));

        // Random legal commands against random back-pressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 120; i++)
                    send($urandom_range(0, 13), $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 31), $urandom_range(0, 65535), $urandom);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #2 wr_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk);
        #2 wr_ready = 1'b1;
        drain();
        check("rand_count", 64'(count), 64'(model_count));
        check("rand_wrapped", 64'(wrapped), 64'(model_wrapped));

        // Address wrap and count saturation.
        do_clear();
        for (int i = 0; i < 65; i++) send(9, 1, 2, 0, i, 0);
        drain();
        check("wrap_flag", 64'(wrapped), 64'd1);
        check("wrap_count", 64'(count), 64'd64);
        check("wrap_addr", 64'(wr_addr), 64'd1);

        // Illegal opcode.
        do_clear();
        send(15, 1, 2, 3, 4, 5);
        repeat (3) @(negedge clk);
`ifdef ENC_ILLEGAL_CHECK_EN
        check("illegal_err", 64'(err_illegal), 64'd1);
        check("illegal_no_write", 64'(count), 64'd0);
`else
        drain();
        check("illegal_err", 64'(err_illegal), 64'd0);
        check("illegal_nop_count", 64'(count), 64'd1);
`endif
        do_clear();
        #1;
        check("clr_err", 64'(err_illegal), 64'd0);
        check("clr_count", 64'(count), 64'd0);
        check("clr_wrapped", 64'(wrapped), 64'd0);
        check("clr_addr", 64'(wr_addr), 64'd0);

        // Reset mid-stream with one word pending and three in the FIFO.
        send(2, 1, 1, 1, 0, 0);
        drain();
        @(posedge clk);
        #2 wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3, i, i, i, 0, 0);
        @(negedge clk);
        check("pre_rst_valid", 64'(wr_valid), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(wr_valid), 64'd0);
        check("async_rst_addr", 64'(wr_addr), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        model_addr = '0; model_count = 0; model_wrapped = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        wr_ready = 1'b1;
        send(10, 7, 6, 0, 16'h1234, 0);
        drain();
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_addr", 64'(wr_addr), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
